// File: rtl/uart_rx_byte.sv
//------------------------------------------------------------------------------
// uart_rx_byte
//
// Purpose:
//    Asynchronous serial receiver for the rx232 pin (8N1, LSB first, idle
//    high). A 2-flop synchronizer brings rx into the clk domain. The start
//    bit is confirmed at its middle, and each data bit and the stop bit are
//    then sampled one bit period apart. Completed bytes are offered on a
//    valid/ready holding register. Framing errors and overruns are flagged
//    as single-cycle pulses.
//
// Parameters:
//    CLKS_PER_BIT  clk cycles per serial bit (minimum 8)
//    DATA_BITS     data bits per frame (width of rx_data)
//
// Ports:
//    clk        in   system clock, all logic on the rising edge
//    reset_n    in   synchronous active-low reset
//    rx         in   raw serial line, asynchronous to clk, idle high
//    rx_data    out  received byte, stable while rx_valid is high
//    rx_valid   out  holding register full
//    rx_ready   in   consumer takes the byte when rx_valid && rx_ready
//    frame_err  out  1-cycle pulse: stop bit sampled low
//    overrun    out  1-cycle pulse: new byte dropped, holding register full
//    busy       out  high while the receiver is not idle
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 417,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_BITS + 1);

   // Terminal counts: the start bit is checked half a bit after the edge,
   // every later sample is one full bit period after the previous one.
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

   localparam logic [IW-1:0] IDX_ZERO  = IW'(0);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_t;

   state_t                 state;
   logic                   rx_meta;
   logic                   rx_s;
   logic                   rx_prev;
   logic                   fall;
   logic [CW-1:0]          cnt;
   logic [IW-1:0]          idx;
   logic [DATA_BITS-1:0]   shift;
   logic                   byte_done;

   // A start edge is the synchronized line going low after being high.
   assign fall = rx_prev & ~rx_s;

   // Two-flop synchronizer plus one history flop for edge detection;
   // all reset to the idle (high) line level so reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Receive state machine and holding-register delivery.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         cnt       <= CNT_ZERO;
         idx       <= IDX_ZERO;
         shift     <= {DATA_BITS{1'b0}};
         byte_done <= 1'b0;
         rx_data   <= {DATA_BITS{1'b0}};
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         // Pulse outputs default low; the branches below raise them.
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         byte_done <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (fall) begin
                  cnt   <= CNT_ZERO;
                  state <= ST_START;
                  busy  <= 1'b1;
               end
            end

            ST_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= CNT_ZERO;
                  if (rx_s) begin
                     // Line is back high at mid start bit: a glitch.
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     idx   <= IDX_ZERO;
                     state <= ST_DATA;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            ST_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt <= CNT_ZERO;
                  // Shift in from the top: after DATA_BITS samples the
                  // first (least significant) bit sits at bit 0.
                  shift <= {rx_s, shift[DATA_BITS-1:1]};
                  if (idx == IDX_LAST) begin
                     state <= ST_STOP;
                  end else begin
                     idx <= idx + IDX_ONE;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            ST_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= CNT_ZERO;
                  if (rx_s) begin
                     byte_done <= 1'b1;
                     state     <= ST_IDLE;
                     busy      <= 1'b0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= ST_BREAK;
                  end
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end

            ST_BREAK: begin
               // Absorb a held-low line so it yields one frame_err only.
               if (rx_s) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end

            default: begin
               state <= ST_IDLE;
               cnt   <= CNT_ZERO;
               idx   <= IDX_ZERO;
               busy  <= 1'b0;
            end
         endcase

         // Delivery runs one cycle after the good stop sample. A consumer
         // taking the old byte in that same cycle frees room for the new one.
         if (byte_done) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps

module tb_uart_rx_byte;

   localparam int  CPB    = 16;
   localparam real BIT_NS = 160.0;

   logic       clk      = 1'b0;
   logic       reset_n  = 1'b0;
   logic       rx       = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   // Monitor results, written only by the monitor process.
   logic [7:0] got [0:63];
   int         got_n = 0;
   int         fe_n  = 0;
   int         ov_n  = 0;

   always #5 clk = ~clk;

   uart_rx_byte #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .rx        (rx),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   // Inputs change just after posedge, so negedge values are the ones the
   // DUT uses at the next posedge: log real transfers and pulses here.
   always @(negedge clk) begin
      if (rx_valid && rx_ready && got_n < 64) begin
         got[got_n] <= rx_data;
         got_n      <= got_n + 1;
      end
      if (frame_err) fe_n <= fe_n + 1;
      if (overrun)   ov_n <= ov_n + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input real bit_ns);
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         #(bit_ns);
      end
      rx = stop_b;
      #(bit_ns);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq({tag, "_data"},  32'(rx_data),   32'h0);
      check_eq({tag, "_valid"}, 32'(rx_valid),  32'h0);
      check_eq({tag, "_ferr"},  32'(frame_err), 32'h0);
      check_eq({tag, "_ovr"},   32'(overrun),   32'h0);
      check_eq({tag, "_busy"},  32'(busy),      32'h0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1);
   end

   initial begin
      int  base;
      int  fe0;
      int  ov0;
      int  k;
      real bps [0:2];
      bps[0] = 160.0;
      bps[1] = 155.0;
      bps[2] = 165.0;

      // Reset state
      wait_clks(3);
      check_outputs_zero("rst");
      reset_n = 1'b1;
      wait_clks(5);

      // 1: two back-to-back bytes
      rx_ready = 1'b1;
      base = got_n; fe0 = fe_n; ov0 = ov_n;
      send_frame(8'h55, 1'b1, BIT_NS);
      send_frame(8'hA3, 1'b1, BIT_NS);
      wait_clks(20);
      check_eq("t1_count", 32'(got_n - base), 32'd2);
      check_eq("t1_byte0", 32'(got[base]),     32'h55);
      check_eq("t1_byte1", 32'(got[base + 1]), 32'hA3);
      check_eq("t1_ferr",  32'(fe_n - fe0),    32'd0);
      check_eq("t1_ovr",   32'(ov_n - ov0),    32'd0);
      check_eq("t1_busy",  32'(busy),          32'h0);

      // 2: 5-cycle glitch is a false start
      base = got_n; fe0 = fe_n;
      rx = 1'b0;
      #50;
      check_eq("t2_busy_start", 32'(busy), 32'h1);
      rx = 1'b1;
      wait_clks(30);
      check_eq("t2_count", 32'(got_n - base), 32'd0);
      check_eq("t2_ferr",  32'(fe_n - fe0),   32'd0);
      check_eq("t2_busy",  32'(busy),         32'h0);

      // 3: bad stop bit, line held low, then a good byte
      base = got_n; fe0 = fe_n;
      send_frame(8'h3C, 1'b0, BIT_NS);
      #400;
      check_eq("t3_busy_break", 32'(busy),     32'h1);
      check_eq("t3_valid",      32'(rx_valid), 32'h0);
      rx = 1'b1;
      wait_clks(10);
      check_eq("t3_ferr",  32'(fe_n - fe0),   32'd1);
      check_eq("t3_count", 32'(got_n - base), 32'd0);
      check_eq("t3_busy",  32'(busy),         32'h0);
      send_frame(8'h81, 1'b1, BIT_NS);
      wait_clks(20);
      check_eq("t3_count2", 32'(got_n - base), 32'd1);
      check_eq("t3_byte",   32'(got[base]),    32'h81);
      check_eq("t3_ferr2",  32'(fe_n - fe0),   32'd1);

      // 4: overrun while the register is full
      rx_ready = 1'b0;
      base = got_n; ov0 = ov_n;
      send_frame(8'h11, 1'b1, BIT_NS);
      wait_clks(10);
      check_eq("t4_valid1", 32'(rx_valid), 32'h1);
      check_eq("t4_data1",  32'(rx_data),  32'h11);
      send_frame(8'h22, 1'b1, BIT_NS);
      wait_clks(10);
      check_eq("t4_ovr",    32'(ov_n - ov0), 32'd1);
      check_eq("t4_data2",  32'(rx_data),    32'h11);
      check_eq("t4_valid2", 32'(rx_valid),   32'h1);
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
      check_eq("t4_valid_clr", 32'(rx_valid),     32'h0);
      check_eq("t4_data_hold", 32'(rx_data),      32'h11);
      check_eq("t4_taken",     32'(got_n - base), 32'd1);
      check_eq("t4_taken_val", 32'(got[base]),    32'h11);

      // 5: consumer takes the old byte the cycle the new one lands
      base = got_n; ov0 = ov_n;
      send_frame(8'h11, 1'b1, BIT_NS);
      wait_clks(10);
      check_eq("t5_valid1", 32'(rx_valid), 32'h1);
      fork
         send_frame(8'h22, 1'b1, BIT_NS);
         begin
            k = 0;
            while (!busy && k < 400) begin
               @(posedge clk); #1; k++;
            end
            check_eq("t5_busy_rise", 32'(busy), 32'h1);
            k = 0;
            while (busy && k < 400) begin
               @(posedge clk); #1; k++;
            end
            check_eq("t5_busy_fall", 32'(busy), 32'h0);
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
         end
      join
      wait_clks(5);
      check_eq("t5_data",  32'(rx_data),      32'h22);
      check_eq("t5_valid", 32'(rx_valid),     32'h1);
      check_eq("t5_ovr",   32'(ov_n - ov0),   32'd0);
      check_eq("t5_taken", 32'(got_n - base), 32'd1);
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
      check_eq("t5_valid_clr", 32'(rx_valid), 32'h0);

      // 6: reset mid-DATA, then reception at nominal and +/-3% bit periods
      rx_ready = 1'b1;
      for (int p = 0; p < 3; p++) begin
         fe0 = fe_n; ov0 = ov_n;
         fork
            send_frame(8'hF0, 1'b1, bps[p]);
            begin
               wait_clks(103);
               check_eq("t6_busy_pre", 32'(busy), 32'h1);
               reset_n = 1'b0;
               wait_clks(1);
               reset_n = 1'b1;
               check_outputs_zero("t6_rst");
            end
         join
         wait_clks(20);
         base = got_n;
         send_frame(8'h0F, 1'b1, bps[p]);
         send_frame(8'hC6, 1'b1, bps[p]);
         wait_clks(20);
         check_eq("t6_count", 32'(got_n - base), 32'd2);
         check_eq("t6_byte0", 32'(got[base]),     32'h0F);
         check_eq("t6_byte1", 32'(got[base + 1]), 32'hC6);
         check_eq("t6_ferr",  32'(fe_n - fe0),    32'd0);
         check_eq("t6_ovr",   32'(ov_n - ov0),    32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
